// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory bus between mips_fetch_unit (master) and the memory (slave).
// Requests are accepted on im_req & im_gnt; data returns in grant order on im_rvalid.
interface mips_fetch_unit_if #(parameter int AW = 16);
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_gnt;
  logic          im_rvalid;
  logic [31:0]   im_rdata;

  modport master (output im_req, im_addr, input im_gnt, im_rvalid, im_rdata);
  modport slave  (input im_req, im_addr, output im_gnt, im_rvalid, im_rdata);
endinterface

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage feeding mips_single_cycle.
// Prefetches sequential words into a tagged FIFO. Any PC discontinuity flushes
// the FIFO and restarts fetch at the new PC, draining in-flight reads first.
// Optional macro FETCH_BYPASS_EN: forward im_rdata straight to the core when the
// returning word is the FIFO head and matches PC.
module mips_fetch_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic             clk,
  input  logic             asyn_rst,
  input  logic [31:0]      PC,
  input  logic             fetch_ack,
  output logic [31:0]      instruction,
  output logic             instr_valid,
  output logic             stall,
  mips_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_fetch_ptr, w_fetch_ptr_nxt;
  logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [PW:0]     r_count, r_pend;
  logic [DEPTH-1:0] r_full;
  logic [AW-1:0]   r_tag  [DEPTH];
  logic [31:0]     r_data [DEPTH];
  logic            err_sticky;

  logic [AW-1:0]   w_pc_word;
  logic            w_empty, w_fifo_full, w_tag_match, w_head_full;
  logic            w_redirect, w_hit_buf, w_hit_byp, w_hit, w_pop;
  logic            w_req, w_gnt, w_fill, w_fill_wr;
  logic [PW-1:0]   w_fill_idx;
  logic [PW:0]     w_pend_fill;
  logic            w_unused;

  assign w_pc_word   = PC[AW+1:2];
  assign w_unused    = ^{PC[31:AW+2], PC[1:0]};
  assign w_empty     = (r_count == '0);
  assign w_fifo_full = (r_count == (PW+1)'(DEPTH));
  assign w_tag_match = ~w_empty && (r_tag[r_rd_ptr] == w_pc_word);
  assign w_head_full = r_full[r_rd_ptr];

  // Filled entries are always the oldest ones, so the next slot to fill sits
  // (count - pend) entries past the head.
  assign w_fill_idx  = r_rd_ptr + PW'(r_count - r_pend);
  assign w_fill      = bus.im_rvalid && (r_state == RUN) && (r_pend != '0);
  // Outstanding reads after this cycle's return; a redirect drains exactly these.
  assign w_pend_fill = r_pend - (PW+1)'(w_fill);

  assign w_redirect  = (r_state == RUN) &&
                       (w_empty ? (r_fetch_ptr != w_pc_word) : ~w_tag_match);
  assign w_hit_buf   = (r_state == RUN) && w_tag_match && w_head_full;
`ifdef FETCH_BYPASS_EN
  // A non-full head is necessarily the oldest pending entry, so this return is its data.
  assign w_hit_byp   = (r_state == RUN) && w_tag_match && ~w_head_full && bus.im_rvalid;
`else
  assign w_hit_byp   = 1'b0;
`endif
  assign w_hit       = w_hit_buf | w_hit_byp;
  assign w_pop       = w_hit & fetch_ack;
  assign w_gnt       = w_req & bus.im_gnt;
  // A bypassed word popped in the same cycle never needs to land in the FIFO.
  assign w_fill_wr   = w_fill && ~(w_hit_byp && fetch_ack);

  assign instr_valid = w_hit;
  assign stall       = ~w_hit;
  assign instruction = w_hit_byp ? bus.im_rdata :
                       (w_hit_buf ? r_data[r_rd_ptr] : 32'h0);
  assign bus.im_req  = w_req;
  assign bus.im_addr = r_fetch_ptr;

  // FSM state and fetch pointer registers.
  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      r_state     <= IDLE;
      r_fetch_ptr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_ptr <= w_fetch_ptr_nxt;
    end
  end

  // Next state, fetch pointer and request generation.
  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_ptr_nxt = r_fetch_ptr;
    w_req           = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt     = RUN;
        w_fetch_ptr_nxt = w_pc_word;
      end
      RUN: begin
        if (w_redirect) begin
          if (w_pend_fill == '0) w_fetch_ptr_nxt = w_pc_word;
          else                   w_state_nxt     = DRAIN;
        end else begin
          w_req = ~w_fifo_full;
          if (~w_fifo_full && bus.im_gnt) w_fetch_ptr_nxt = r_fetch_ptr + AW'(1);
        end
      end
      DRAIN: begin
        if (bus.im_rvalid && (r_pend == (PW+1)'(1))) begin
          w_state_nxt     = RUN;
          w_fetch_ptr_nxt = w_pc_word;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FIFO occupancy, pointers, fill flags and outstanding-read count.
  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      r_count  <= '0;
      r_pend   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_full   <= '0;
    end else if (w_redirect) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_full   <= '0;
      r_pend   <= w_pend_fill;
    end else if (r_state == DRAIN) begin
      if (bus.im_rvalid) r_pend <= r_pend - (PW+1)'(1);
    end else begin
      r_pend  <= r_pend + (PW+1)'(w_gnt) - (PW+1)'(w_fill);
      r_count <= r_count + (PW+1)'(w_gnt) - (PW+1)'(w_pop);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_gnt) begin
        r_wr_ptr         <= r_wr_ptr + PW'(1);
        r_full[r_wr_ptr] <= 1'b0;
      end
      if (w_fill_wr) r_full[w_fill_idx] <= 1'b1;
    end
  end

  // Entry payload: tag captured at grant, data at return.
  always_ff @(posedge clk) begin
    if (w_gnt)     r_tag[r_wr_ptr]    <= r_fetch_ptr;
    if (w_fill_wr) r_data[w_fill_idx] <= bus.im_rdata;
  end

  // Sticky flag for a read return with nothing outstanding.
  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst)
      err_sticky <= 1'b0;
    else if (bus.im_rvalid && (r_pend == '0) && (r_state != DRAIN))
      err_sticky <= 1'b1;
  end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit against a queue-based reference model,
// plus directed scenarios for reset, full FIFO, jumps, drain and bypass latency.
module tb_mips_fetch_unit;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        asyn_rst = 1'b1;
  logic [31:0] PC = '0;
  logic        fetch_ack = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid, stall;

  mips_fetch_unit_if #(.AW(AW)) bus ();

  mips_fetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .asyn_rst(asyn_rst), .PC(PC), .fetch_ack(fetch_ack),
    .instruction(instruction), .instr_valid(instr_valid), .stall(stall), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] tag; logic [31:0] data; bit full; } ent_t;
  typedef struct { logic [AW-1:0] addr; int rdy; } rsp_t;
  typedef enum { M_IDLE, M_RUN, M_DRAIN } mst_t;

  ent_t          mq[$];
  rsp_t          mem_q[$];
  mst_t          mst;
  int            mpend;
  logic [AW-1:0] mfp;
  bit            exp_err;

  int gnt_pct, rv_pct, ack_pct, jump_pct, lat_min, lat_max;
  bit force_rv;
  logic [31:0] pc_q;

  int n_tests = 0, n_fail = 0, cyc_n = 0;
  int n_gnt, n_stall, n_valid, rv_hit_cyc, first_gnt_addr, last_gnt_addr;
  bit obs_req, obs_valid;
  logic [AW-1:0] obs_addr;
  logic [31:0]   obs_instr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [AW-1:0] w;
    if ($urandom_range(0, 3) == 0) w = AW'(16'hFFFC + $urandom_range(0, 3));
    else                           w = AW'($urandom_range(0, 40));
    return (32'($urandom_range(0, 15)) << 18) | (32'(w) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    mq.delete(); mem_q.delete();
    mst = M_IDLE; mpend = 0; mfp = '0; exp_err = 0;
  endtask

  // Entered at a negedge; asserts reset mid-cycle, checks, releases at the next negedge.
  task automatic do_reset();
    bus.im_gnt = 0; bus.im_rvalid = 0; bus.im_rdata = '0; fetch_ack = 0;
    #2 asyn_rst = 1'b1;
    #1;
    chk("rst_stall", stall, 1);
    chk("rst_req", bus.im_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_addr", bus.im_addr, 0);
    @(posedge clk);
    @(negedge clk);
    asyn_rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive at negedge, compare after #1, advance the model at posedge.
  task automatic cyc();
    logic [AW-1:0] pcw;
    logic [31:0] rd, einstr;
    bit gnt, ack, rv, from_mem, run, ne, tagm, redirect, hitb, byp, hit, req;
    pcw = pc_q[AW+1:2];
    gnt = ($urandom_range(0, 99) < gnt_pct);
    ack = ($urandom_range(0, 99) < ack_pct);
    rv = 0; from_mem = 0; rd = $urandom;
    if (force_rv) begin
      rv = 1; force_rv = 0;
    end else if (mem_q.size() > 0 && mem_q[0].rdy <= cyc_n && $urandom_range(0, 99) < rv_pct) begin
      rv = 1; from_mem = 1; rd = 32'h2000_0000 + 32'(mem_q[0].addr);
      if (mem_q[0].addr == pcw) rv_hit_cyc = cyc_n;
    end
    PC = pc_q; fetch_ack = ack;
    bus.im_gnt = gnt; bus.im_rvalid = rv; bus.im_rdata = rd;
    #1;
    run  = (mst == M_RUN);
    ne   = (mq.size() > 0);
    tagm = 0; hitb = 0; byp = 0;
    if (ne) begin
      tagm = (mq[0].tag == pcw);
      hitb = run && tagm && mq[0].full;
      byp  = (BYP != 0) && run && tagm && !mq[0].full && rv;
    end
    redirect = run && (ne ? !tagm : (mfp != pcw));
    hit = hitb || byp;
    einstr = hitb ? mq[0].data : (byp ? rd : 32'h0);
    req = run && !redirect && (mq.size() < DEPTH);
    chk("valid", instr_valid, hit);
    chk("instr", instruction, einstr);
    chk("stall", stall, !hit);
    chk("req", bus.im_req, req);
    if (req) chk("addr", bus.im_addr, mfp);
    chk("err", dut.err_sticky, exp_err);
    obs_req = bus.im_req; obs_addr = bus.im_addr;
    obs_valid = instr_valid; obs_instr = instruction;
    if (obs_req && gnt) begin
      if (n_gnt == 0) first_gnt_addr = obs_addr;
      last_gnt_addr = obs_addr;
      n_gnt++;
    end
    if (!obs_valid) n_stall++;
    else            n_valid++;
    @(posedge clk);
    if (from_mem) void'(mem_q.pop_front());
    case (mst)
      M_IDLE: begin
        if (rv) exp_err = 1;
        mst = M_RUN; mfp = pcw;
      end
      M_DRAIN: begin
        if (rv) begin
          mpend--;
          if (mpend == 0) begin mst = M_RUN; mfp = pcw; end
        end
      end
      default: begin
        if (rv && mpend > 0) begin
          for (int i = 0; i < mq.size(); i++)
            if (!mq[i].full) begin mq[i].data = rd; mq[i].full = 1; break; end
          mpend--;
        end else if (rv) exp_err = 1;
        if (redirect) begin
          mq.delete();
          if (mpend == 0) mfp = pcw;
          else            mst = M_DRAIN;
        end else begin
          if (hit && ack) void'(mq.pop_front());
          if (req && gnt) begin
            mq.push_back('{tag: mfp, data: 32'h0, full: 0});
            mem_q.push_back('{addr: mfp, rdy: cyc_n + $urandom_range(lat_min, lat_max)});
            mpend++;
            mfp = mfp + AW'(1);
          end
        end
      end
    endcase
    if (hit && ack) pc_q = pc_q + 32'd4;
    if (jump_pct > 0 && $urandom_range(0, 99) < jump_pct) pc_q = rand_pc();
    cyc_n++;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int valid_cyc;
    gnt_pct = 100; rv_pct = 100; ack_pct = 0; jump_pct = 0; lat_min = 1; lat_max = 1;
    force_rv = 0; pc_q = 32'h0; n_gnt = 0; n_stall = 0; n_valid = 0; rv_hit_cyc = -1;
    first_gnt_addr = -1; last_gnt_addr = -1;
    bus.im_gnt = 0; bus.im_rvalid = 0; bus.im_rdata = '0;
    @(negedge clk);
    do_reset();

    // First request on the second cycle, then the FIFO fills with 4 grants.
    n_gnt = 0;
    cyc(); chk("idle_req", obs_req, 0);
    cyc(); chk("first_req", obs_req, 1); chk("first_addr", obs_addr, 0);
    repeat (8) cyc();
    chk("full_grants", n_gnt, 4);
    chk("full_noreq", obs_req, 0);
    n_gnt = 0; ack_pct = 100;
    cyc();
    ack_pct = 0;
    repeat (3) cyc();
    chk("ack_grants", n_gnt, 1);
    chk("ack_addr", last_gnt_addr, 4);

    // Jump to word 10 with nothing outstanding.
    pc_q = 32'h28; rv_hit_cyc = -1; valid_cyc = -1;
    cyc();
    cyc(); chk("jmp_req", obs_req, 1); chk("jmp_addr", obs_addr, 10);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (obs_valid) begin valid_cyc = cyc_n - 1; break; end
    end
    chk("jmp_seen", valid_cyc >= 0, 1);
    chk("jmp_instr", obs_instr, 32'h2000_000A);
    chk("byp_lat", valid_cyc - rv_hit_cyc, BYP ? 0 : 1);

    // Zero-wait sequential stream.
    ack_pct = 100;
    repeat (10) cyc();
    n_stall = 0;
    repeat (40) cyc();
    chk("stream_stall", n_stall, 0);

    // Jump while two reads are outstanding.
    lat_min = 5; lat_max = 5; ack_pct = 0; pc_q = 32'h0;
    do_reset();
    cyc(); cyc(); cyc();
    pc_q = 32'h50; n_gnt = 0; n_valid = 0;
    for (int i = 0; i < 20 && n_gnt == 0; i++) cyc();
    chk("drain_gnt", n_gnt, 1);
    chk("drain_addr", first_gnt_addr, 20);
    chk("drain_novalid", n_valid, 0);

    // Randomized traffic with jumps, stalls, variable latency and resets.
    for (int blk = 0; blk < 15; blk++) begin
      gnt_pct  = $urandom_range(30, 100);
      rv_pct   = $urandom_range(30, 100);
      ack_pct  = $urandom_range(20, 100);
      jump_pct = $urandom_range(0, 8);
      lat_min  = 1;
      lat_max  = $urandom_range(1, 4);
      if (blk % 5 == 4) begin pc_q = rand_pc(); do_reset(); end
      repeat (200) cyc();
    end

    // Read return with nothing outstanding sets the sticky error.
    gnt_pct = 0; rv_pct = 0; jump_pct = 0; ack_pct = 0; pc_q = 32'h0;
    do_reset();
    cyc();
    force_rv = 1;
    cyc();
    cyc();
    chk("err_flag", dut.err_sticky, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch stage sitting directly upstream of `mips_single_cycle`, driving its `instruction` input from its `PC` output. Issues pipelined, in-order word reads to a variable-latency instruction memory, buffers them in a tagged prefetch FIFO, and flags a stall when the instruction for the current `PC` is not yet available. Sequential prefetch runs ahead of the core. Any `PC` discontinuity (J, JAL, RET, taken branch) flushes the buffer and restarts fetch at the new `PC`.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, 2..16.
- `AW`, 16: instruction memory word-address width.

- `clk`  in  1  rising-edge clock.
- `asyn_rst`  in  1  asynchronous, active-high reset.
- `PC`  in  32  byte address from core; bits [1:0] ignored; word address = `PC[AW+1:2]`.
- `fetch_ack`  in  1  core retires the presented instruction this cycle; ignored unless `instr_valid`.
- `instruction`  out  32  instruction for `PC`; 0 when `instr_valid`=0.
- `instr_valid`  out  1  `instruction` matches current `PC`.
- `stall`  out  1  `~instr_valid`.
- `im_req`  out  1  read request.
- `im_addr`  out  AW  word address of request.
- `im_gnt`  in  1  request accepted in the cycle `im_req`&`im_gnt`.
- `im_rvalid`  in  1  read data return, in grant order, ≥1 cycle after grant.
- `im_rdata`  in  32  read data.

## Operation
- FIFO entry fields: `tag[AW-1:0]`, `data[31:0]`, `full` (data arrived). Entry allocated at grant with `tag=im_addr`, `full=0`. Filled in order by `im_rvalid`.
- `fetch_ptr` (AW bits) holds the next sequential address. It increments by 1 per grant and wraps modulo 2^AW.
- `pend` counts allocated-not-filled entries.
- FSM states:
  - IDLE: entered on reset; `im_req`=0; moves to RUN next cycle with `fetch_ptr`=`PC` word.
  - RUN: `im_req`=1 while FIFO not full (allocated < DEPTH); `im_addr`=`fetch_ptr`.
  - DRAIN: `im_req`=0; discards each `im_rvalid` until `pend`=0, then loads `fetch_ptr`=`PC` word and moves to RUN.
- Hit (RUN only): FIFO non-empty, head `tag`=`PC` word, head `full`=1. Drives `instr_valid`=1 and `instruction`=head `data`.
- `fetch_ack`&hit pops the head.
- Redirect (RUN only), either condition:
  - FIFO non-empty and head `tag`≠`PC` word;
  - FIFO empty and `fetch_ptr`≠`PC` word.
- On redirect, evaluated combinationally in cycle t:
  - no hit and no request in t;
  - at the edge, all entries are cleared;
  - if `pend`=0: `fetch_ptr`←`PC` word and stay in RUN;
  - otherwise: record `pend` as the discard count and go to DRAIN.
- Same cycle grant + rvalid + pop: all three apply. Occupancy changes by (grant − pop).
- An `im_rvalid` with `pend`=0 outside DRAIN is a protocol error. It is ignored, and `err_sticky` (internal, visible to the bench) is set.
- Reset mid-operation: FIFO, `pend` and FSM clear immediately. Responses to pre-reset grants are not discarded, so the bench must not return any after reset.

## Timing
- Reset values: `instruction`=0, `instr_valid`=0, `stall`=1, `im_req`=0, `im_addr`=0.
- First `im_req` appears the second cycle after reset release, with `im_addr`=`PC` word.
- Latency without bypass: `im_rvalid` in cycle t gives `instr_valid` in t+1.
- Steady state with zero-wait memory (gnt=1, rvalid one cycle after grant): one instruction per cycle, no stall after warm-up.
- Redirect with `pend`=0: request for the new `PC` in t+1; earliest `instr_valid` in t+3 without bypass.
- Redirect with `pend`=k: DRAIN lasts until the k-th discarded rvalid; RUN resumes the following cycle.
- `instruction`, `instr_valid` and `stall` are combinational from `PC` and FIFO state. `im_req` and `im_addr` are combinational from FSM, `fetch_ptr` and occupancy.

## Configuration
- `FETCH_BYPASS_EN` defined: when the FIFO head is the oldest pending entry with tag = `PC` word and `im_rvalid`=1 in RUN, `instr_valid`=1 and `instruction`=`im_rdata` in the same cycle. `fetch_ack` then pops it directly; the entry is not written full.
- Undefined: no bypass; data becomes visible one cycle after `im_rvalid`.

## Test plan
- Reset: `asyn_rst`=1 mid-cycle → `stall`=1 and `im_req`=0 immediately. After release with `PC`=0, `im_addr`=0 on the second cycle.
- Sequential stream: zero-wait memory returning `0x20000000+addr`, `PC` stepping 0,4,8,… with `fetch_ack`=1 → after warm-up, `instruction`=0x20000000,0x20000001,… every cycle with `stall`=0.
- Full FIFO: `DEPTH`=4, `fetch_ack`=0 → exactly 4 grants (addr 0..3), then `im_req`=0. One ack → one new grant at addr 4.
- Jump with nothing pending: all 4 entries full, `PC` jumps to 0x28 (word 10) → flush, `im_addr`=10 next cycle, `instruction`=0x2000000A after the return.
- Jump while pending: 2 requests outstanding, `PC`→0x50 → DRAIN; both returns discarded; first request after DRAIN is `im_addr`=20; no stale instruction presented.
- Bypass: with `FETCH_BYPASS_EN`, `im_rvalid` for the `PC` word → `instr_valid`=1 the same cycle. Without it → `instr_valid`=1 one cycle later.
